bit_population_counter_stream: RTL and testbench
================================================

BIT_POPULATION_COUNTER_STREAM -- requirements
Module: bit_population_counter_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 128: input word width; legal range 2..1024.
REQ-002 SHALL have parameter PIPE_SIZE, default 2: number of register stages in the count path; legal range 1..$clog2(WIDTH).
REQ-003 SHALL have parameter ACC_WIDTH, default 16: frame accumulator width; legal range >= $clog2(WIDTH)+1.
REQ-004 SHALL have clk_i, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have arst_n_i, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have data_i, input, WIDTH: word to count.
REQ-007 SHALL have data_val_i, input, 1: data_i valid.
REQ-008 SHALL have data_last_i, input, 1: word is the last of a frame.
REQ-009 SHALL have mode_i, input, 1: 0 = count ones, 1 = count zeros; sampled with the word.
REQ-010 SHALL have data_ready_o, output, 1: block accepts a word this cycle.
REQ-011 SHALL have data_o, output, $clog2(WIDTH)+1: per-word count.
REQ-012 SHALL have data_val_o, output, 1: data_o valid.
REQ-013 SHALL have data_last_o, output, 1: data_o belongs to a frame-last word.
REQ-014 SHALL have frame_cnt_o, output, ACC_WIDTH: running frame sum including the current data_o.
REQ-015 SHALL have frame_ovf_o, output, 1: frame sum saturated.
REQ-016 SHALL have data_ready_i, input, 1: downstream accepts the output.

Function
REQ-017 Input handshake SHALL occur on a cycle with data_val_i && data_ready_o; output handshake SHALL occur on a cycle with data_val_o && data_ready_i.
REQ-018 data_ready_o SHALL equal !data_val_o || data_ready_i, combinationally; the pipeline advances only when data_ready_o=1.
REQ-019 Pipeline stall SHALL freeze every stage, including its valid, last and mode bits; no word SHALL be dropped or duplicated.
REQ-020 Without stall, a word accepted at edge N SHALL appear on data_o with data_val_o=1 after edge N+PIPE_SIZE-1.
REQ-021 data_o SHALL be popcount(data_i) for mode 0, or WIDTH - popcount(data_i) for mode 1; range 0..WIDTH with no truncation.
REQ-022 The adder tree SHALL be split into PIPE_SIZE balanced register stages; bubbles (data_val_i=0) SHALL propagate as data_val_o=0.
REQ-023 frame_cnt_o SHALL be the registered accumulator value plus data_o, saturated at 2^ACC_WIDTH-1; it is meaningful only when data_val_o=1.
REQ-024 On an output handshake with data_last_o=0, the accumulator SHALL load frame_cnt_o; with data_last_o=1, it SHALL load 0.
REQ-025 frame_ovf_o SHALL be 1 when the unsaturated sum exceeds 2^ACC_WIDTH-1, or a sticky overflow flag is set.
REQ-026 The sticky overflow flag SHALL set on an output handshake with overflow and data_last_o=0, and SHALL clear on a handshake with data_last_o=1.
REQ-027 mode_i SHALL be per-word; mixed modes within a frame SHALL be summed as produced.
REQ-028 Single-word frame: data_last_i=1 on the first word SHALL give frame_cnt_o = data_o.
REQ-029 While data_val_o=1 and data_ready_i=0, data_o, data_last_o, frame_cnt_o and frame_ovf_o SHALL stay stable.

Reset
REQ-030 arst_n_i=0 SHALL immediately clear all pipeline valids, data, last and mode bits, the accumulator and the overflow flag.
REQ-031 During reset: data_val_o=0, data_o=0, data_last_o=0, frame_cnt_o=0, frame_ovf_o=0, data_ready_o=1.
REQ-032 Reset mid-frame SHALL discard in-flight words and the partial frame sum; the first word after deassertion starts a new frame.
REQ-033 Words presented on the cycle reset deasserts SHALL not be accepted; acceptance SHALL begin on the first edge with arst_n_i=1.

Verification
REQ-034 WIDTH=128, PIPE_SIZE=2, ready=1, sequence: all-ones, zero, 0xAAAA..A with mode 0 -> data_o 128, 0, 64 on consecutive cycles, each 2 cycles after its input.
REQ-035 mode 1, data 0x0F (upper bits 0) -> data_o=124; data all-ones in mode 1 -> 0.
REQ-036 Frame of 3 words with counts 5, 7, 9, the last marked -> frame_cnt_o 5, 12, 21, with data_last_o=1 on 21; the next frame restarts at its first count.
REQ-037 ACC_WIDTH=8, frame of 3 all-ones 128-bit words -> frame_cnt_o 128, 255, 255 and frame_ovf_o 0, 1, 1; next frame frame_ovf_o=0.
REQ-038 Random data_ready_i toggling over 10k random words -> output matches the in-order reference model, with no loss, duplication or output change while stalled.
REQ-039 arst_n_i pulsed low with 2 words in flight mid-frame -> outputs zero immediately; the post-reset frame sum excludes pre-reset words.

Source files
------------

// File: rtl/bit_population_counter_stream.sv
// Streaming popcount with a PIPE_SIZE-stage balanced adder tree and a saturating per-frame accumulator.
// Count mode is folded into the first stage by inverting the word, so no mode bit rides the pipeline.
module bit_population_counter_stream #(
    parameter int WIDTH     = 128,
    parameter int PIPE_SIZE = 2,
    parameter int ACC_WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     arst_n_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     data_val_i,
    input  logic                     data_last_i,
    input  logic                     mode_i,
    output logic                     data_ready_o,
    output logic [$clog2(WIDTH):0]   data_o,
    output logic                     data_val_o,
    output logic                     data_last_o,
    output logic [ACC_WIDTH-1:0]     frame_cnt_o,
    output logic                     frame_ovf_o,
    input  logic                     data_ready_i
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int CNT_W  = LEVELS + 1;
    localparam int NPAD   = 1 << LEVELS;
    localparam int NG_MAX = NPAD >> (LEVELS / PIPE_SIZE);
    localparam int SUM_W  = ACC_WIDTH + 1;

    // Tree level reached at the output of stage s; levels are spread evenly over the stages.
    function automatic int stage_lvl(input int s);
        return ((s + 1) * LEVELS) / PIPE_SIZE;
    endfunction

    logic [NPAD-1:0]      bits_in;
    logic [CNT_W-1:0]     grp_q [PIPE_SIZE][NG_MAX];
    logic [CNT_W-1:0]     grp_d [PIPE_SIZE][NG_MAX];
    logic [PIPE_SIZE-1:0] val_q, val_d;
    logic [PIPE_SIZE-1:0] last_q, last_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 ovf_q, ovf_d;
    logic [SUM_W-1:0]     sum_full;
    logic                 sat;
    logic                 out_hs;

    assign data_val_o   = val_q[PIPE_SIZE-1];
    assign data_last_o  = last_q[PIPE_SIZE-1];
    assign data_o       = grp_q[PIPE_SIZE-1][0];
    assign data_ready_o = !data_val_o || data_ready_i;
    assign out_hs       = data_val_o && data_ready_i;

    always_comb begin
        bits_in = '0;
        bits_in[WIDTH-1:0] = mode_i ? ~data_i : data_i;
    end

    always_comb begin
        grp_d  = grp_q;
        val_d  = val_q;
        last_d = last_q;
        if (data_ready_o) begin
            for (int s = 0; s < PIPE_SIZE; s++) begin
                for (int g = 0; g < NG_MAX; g++) begin
                    grp_d[s][g] = '0;
                end
            end
            for (int g = 0; g < (NPAD >> stage_lvl(0)); g++) begin
                for (int b = 0; b < (1 << stage_lvl(0)); b++) begin
                    grp_d[0][g] = grp_d[0][g] + CNT_W'(bits_in[g * (1 << stage_lvl(0)) + b]);
                end
            end
            for (int s = 1; s < PIPE_SIZE; s++) begin
                for (int g = 0; g < (NPAD >> stage_lvl(s)); g++) begin
                    for (int r = 0; r < (1 << (stage_lvl(s) - stage_lvl(s - 1))); r++) begin
                        grp_d[s][g] = grp_d[s][g]
                            + grp_q[s - 1][g * (1 << (stage_lvl(s) - stage_lvl(s - 1))) + r];
                    end
                end
            end
            val_d  = (val_q << 1) | PIPE_SIZE'(data_val_i);
            last_d = (last_q << 1) | PIPE_SIZE'(data_val_i && data_last_i);
        end
    end

    always_comb begin
        sum_full    = {1'b0, acc_q} + SUM_W'(data_o);
        sat         = sum_full[ACC_WIDTH];
        frame_cnt_o = sat ? '1 : sum_full[ACC_WIDTH-1:0];
        frame_ovf_o = sat || ovf_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        if (out_hs) begin
            if (data_last_o) begin
                acc_d = '0;
                ovf_d = 1'b0;
            end else begin
                acc_d = frame_cnt_o;
                ovf_d = frame_ovf_o;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            grp_q  <= '{default: '0};
            val_q  <= '0;
            last_q <= '0;
            acc_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            grp_q  <= grp_d;
            val_q  <= val_d;
            last_q <= last_d;
            acc_q  <= acc_d;
            ovf_q  <= ovf_d;
        end
    end

endmodule

// File: tb/tb_bit_population_counter_stream.sv
// Bench for bit_population_counter_stream: directed vector table, stall and mid-frame reset
// sequences, then a long random-backpressure run against an in-order reference queue.
module tb_bit_population_counter_stream;

    localparam int W = 128;

    logic         clk_i = 1'b0;
    logic         arst_n_i;
    logic [W-1:0] data_i;
    logic         data_val_i, data_last_i, mode_i, data_ready_i;
    logic         data_ready_o, data_val_o, data_last_o, frame_ovf_o;
    logic [7:0]   data_o;
    logic [15:0]  frame_cnt_o;
    logic         ready8_o, val8_o, last8_o, ovf8_o;
    logic [7:0]   data8_o;
    logic [7:0]   frame8_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    bit_population_counter_stream #(.WIDTH(W), .PIPE_SIZE(2), .ACC_WIDTH(16)) dut (
        .clk_i(clk_i), .arst_n_i(arst_n_i), .data_i(data_i), .data_val_i(data_val_i),
        .data_last_i(data_last_i), .mode_i(mode_i), .data_ready_o(data_ready_o),
        .data_o(data_o), .data_val_o(data_val_o), .data_last_o(data_last_o),
        .frame_cnt_o(frame_cnt_o), .frame_ovf_o(frame_ovf_o), .data_ready_i(data_ready_i)
    );

    bit_population_counter_stream #(.WIDTH(W), .PIPE_SIZE(2), .ACC_WIDTH(8)) dut8 (
        .clk_i(clk_i), .arst_n_i(arst_n_i), .data_i(data_i), .data_val_i(data_val_i),
        .data_last_i(data_last_i), .mode_i(mode_i), .data_ready_o(ready8_o),
        .data_o(data8_o), .data_val_o(val8_o), .data_last_o(last8_o),
        .frame_cnt_o(frame8_o), .frame_ovf_o(ovf8_o), .data_ready_i(data_ready_i)
    );

    typedef struct {
        logic [W-1:0] data;
        bit           val;
        bit           mode;
        bit           last;
        int           cnt;
        int           f16;
        bit           o16;
        int           f8;
        bit           o8;
    } vec_t;

    typedef struct {
        int cnt;
        bit last;
        int f16;
        bit o16;
        int f8;
        bit o8;
    } exp_t;

    vec_t vt [17];
    exp_t q [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [W-1:0] d, input bit v, input bit m, input bit l,
                                input int c, input int f16, input bit o16, input int f8, input bit o8);
        vec_t r;
        r.data = d; r.val = v; r.mode = m; r.last = l; r.cnt = c;
        r.f16 = f16; r.o16 = o16; r.f8 = f8; r.o8 = o8;
        return r;
    endfunction

    task automatic drive(input logic [W-1:0] d, input bit v, input bit m, input bit l);
        data_i = d; data_val_i = v; mode_i = m; data_last_i = l;
    endtask

    task automatic check_out(input string nm, input int cnt, input int f16, input bit last);
        chk({nm, "_val"}, 64'(data_val_o), 64'(1));
        chk({nm, "_data"}, 64'(data_o), 64'(cnt));
        chk({nm, "_frame"}, 64'(frame_cnt_o), 64'(f16));
        chk({nm, "_last"}, 64'(data_last_o), 64'(last));
    endtask

    // Random-run state
    int          sent, cyc, pc, cnt, s16, s8, m16, m8;
    bit          mo16, mo8, pend, stall_prev;
    logic [63:0] saved;
    exp_t        e, got;

    initial begin
        vt[0]  = mk({W{1'b1}},        1, 0, 1, 128, 128, 0, 128, 0);
        vt[1]  = mk('0,               1, 0, 1,   0,   0, 0,   0, 0);
        vt[2]  = mk({(W/2){2'b10}},   1, 0, 1,  64,  64, 0,  64, 0);
        vt[3]  = mk(128'h0F,          1, 1, 1, 124, 124, 0, 124, 0);
        vt[4]  = mk({W{1'b1}},        1, 1, 1,   0,   0, 0,   0, 0);
        vt[5]  = mk(128'h1F,          1, 0, 0,   5,   5, 0,   5, 0);
        vt[6]  = mk(128'h7F,          1, 0, 0,   7,  12, 0,  12, 0);
        vt[7]  = mk(128'h1FF,         1, 0, 1,   9,  21, 0,  21, 0);
        vt[8]  = mk(128'h7,           1, 0, 0,   3,   3, 0,   3, 0);
        vt[9]  = mk({W{1'b1}},        0, 0, 1,   0,   0, 0,   0, 0);
        vt[10] = mk(128'h0F,          1, 1, 1, 124, 127, 0, 127, 0);
        vt[11] = mk('0,               1, 1, 0, 128, 128, 0, 128, 0);
        vt[12] = mk(128'h1,           1, 1, 1, 127, 255, 0, 255, 0);
        vt[13] = mk({W{1'b1}},        1, 0, 0, 128, 128, 0, 128, 0);
        vt[14] = mk({W{1'b1}},        1, 0, 0, 128, 256, 0, 255, 1);
        vt[15] = mk({W{1'b1}},        1, 0, 1, 128, 384, 0, 255, 1);
        vt[16] = mk(128'h3,           1, 0, 1,   2,   2, 0,   2, 0);

        // Reset with a word offered and downstream not ready
        arst_n_i = 1'b0;
        data_ready_i = 1'b0;
        drive({W{1'b1}}, 1, 0, 1);
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_val", 64'(data_val_o), 64'(0));
        chk("rst_data", 64'(data_o), 64'(0));
        chk("rst_last", 64'(data_last_o), 64'(0));
        chk("rst_frame", 64'(frame_cnt_o), 64'(0));
        chk("rst_ovf", 64'(frame_ovf_o), 64'(0));
        chk("rst_ready", 64'(data_ready_o), 64'(1));
        @(negedge clk_i);
        arst_n_i = 1'b1;
        data_val_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Vector table, streamed back to back; output k-1 is visible after edge k
        data_ready_i = 1'b1;
        for (int k = 0; k <= 17; k++) begin
            if (k < 17) drive(vt[k].data, vt[k].val, vt[k].mode, vt[k].last);
            else data_val_i = 1'b0;
            @(posedge clk_i);
            #1;
            if (k >= 1) begin
                chk($sformatf("vec%0d_val", k - 1), 64'(data_val_o), 64'(vt[k-1].val));
                if (vt[k-1].val) begin
                    chk($sformatf("vec%0d_data", k - 1), 64'(data_o), 64'(vt[k-1].cnt));
                    chk($sformatf("vec%0d_last", k - 1), 64'(data_last_o), 64'(vt[k-1].last));
                    chk($sformatf("vec%0d_f16", k - 1), 64'(frame_cnt_o), 64'(vt[k-1].f16));
                    chk($sformatf("vec%0d_o16", k - 1), 64'(frame_ovf_o), 64'(vt[k-1].o16));
                    chk($sformatf("vec%0d_f8", k - 1), 64'(frame8_o), 64'(vt[k-1].f8));
                    chk($sformatf("vec%0d_o8", k - 1), 64'(ovf8_o), 64'(vt[k-1].o8));
                end
            end
        end

        // Stall: output held while downstream is not ready, input word not taken
        drive(128'h1F, 1, 0, 0);
        @(posedge clk_i); #1;
        drive(128'h7F, 1, 0, 0);
        @(posedge clk_i); #1;
        data_ready_i = 1'b0;
        drive(128'h1FF, 1, 0, 1);
        #1;
        chk("stall_ready", 64'(data_ready_o), 64'(0));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1;
            check_out($sformatf("stall%0d", i), 5, 5, 0);
            chk($sformatf("stall%0d_ready", i), 64'(data_ready_o), 64'(0));
        end
        data_ready_i = 1'b1;
        @(posedge clk_i); #1;
        data_val_i = 1'b0;
        check_out("unstall_w1", 7, 12, 0);
        @(posedge clk_i); #1;
        check_out("unstall_w2", 9, 21, 1);
        @(posedge clk_i); #1;
        chk("unstall_drained", 64'(data_val_o), 64'(0));

        // Reset mid-frame with two words in flight
        drive(128'h1F, 1, 0, 0);
        @(posedge clk_i); #1;
        drive(128'h7F, 1, 0, 0);
        @(posedge clk_i); #1;
        drive(128'h1FF, 1, 0, 0);
        @(posedge clk_i); #1;
        data_val_i = 1'b0;
        data_ready_i = 1'b0;
        #2;
        arst_n_i = 1'b0;
        #1;
        chk("midrst_val", 64'(data_val_o), 64'(0));
        chk("midrst_data", 64'(data_o), 64'(0));
        chk("midrst_frame", 64'(frame_cnt_o), 64'(0));
        chk("midrst_ovf", 64'(frame_ovf_o), 64'(0));
        chk("midrst_ready", 64'(data_ready_o), 64'(1));
        @(negedge clk_i);
        arst_n_i = 1'b1;
        data_ready_i = 1'b1;
        drive(128'h7, 1, 0, 1);
        @(posedge clk_i); #1;
        data_val_i = 1'b0;
        @(posedge clk_i); #1;
        check_out("postrst", 3, 3, 1);
        @(posedge clk_i); #1;

        // Random backpressure against the in-order reference queue
        sent = 0; cyc = 0; m16 = 0; m8 = 0; mo16 = 0; mo8 = 0; pend = 0; stall_prev = 0;
        saved = '0;
        while ((sent < 10000 || q.size() > 0) && cyc < 60000) begin
            if (stall_prev)
                chk("rnd_stable", {38'd0, data_o, data_last_o, frame_cnt_o, frame_ovf_o}, saved);
            if (!pend) begin
                if (sent < 10000) begin
                    drive({$urandom(), $urandom(), $urandom(), $urandom()},
                          $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 3) == 0);
                end else begin
                    data_val_i = 1'b0;
                end
            end
            data_ready_i = (sent >= 10000) ? 1'b1 : ($urandom_range(0, 2) != 0);
            #1;
            if (data_val_o && data_ready_i) begin
                if (q.size() == 0) begin
                    chk("rnd_extra_word", 64'(data_val_o), 64'(0));
                end else begin
                    got = q.pop_front();
                    chk("rnd_out16", {38'd0, data_o, data_last_o, frame_cnt_o, frame_ovf_o},
                        {38'd0, 8'(got.cnt), got.last, 16'(got.f16), got.o16});
                    chk("rnd_out8", {55'd0, frame8_o, ovf8_o}, {55'd0, 8'(got.f8), got.o8});
                end
            end
            if (data_val_i && data_ready_o) begin
                pc  = $countones(data_i);
                cnt = mode_i ? (W - pc) : pc;
                s16 = m16 + cnt;
                s8  = m8 + cnt;
                e.cnt  = cnt;
                e.last = data_last_i;
                e.f16  = (s16 > 65535) ? 65535 : s16;
                e.o16  = (s16 > 65535) || mo16;
                e.f8   = (s8 > 255) ? 255 : s8;
                e.o8   = (s8 > 255) || mo8;
                if (data_last_i) begin
                    m16 = 0; mo16 = 0; m8 = 0; mo8 = 0;
                end else begin
                    m16 = e.f16; mo16 = e.o16; m8 = e.f8; mo8 = e.o8;
                end
                q.push_back(e);
                sent++;
                pend = 1'b0;
            end else begin
                pend = data_val_i;
            end
            stall_prev = data_val_o && !data_ready_i;
            saved = {38'd0, data_o, data_last_o, frame_cnt_o, frame_ovf_o};
            @(posedge clk_i);
            #1;
            cyc++;
        end
        chk("rnd_words_sent", 64'(sent), 64'(10000));
        chk("rnd_queue_drained", 64'(q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
